// File: rtl/fifo_rd_stream.sv
// Read-side consumer for the project FIFO: pops into a 3-entry prefetch buffer
// and re-presents the words as a valid/ready stream on the FIFO read clock.
module fifo_rd_stream #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  rd_clk,
    input  logic                  rstn,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    output logic                  fifo_rd_enb,
    input  logic                  flush,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [CNT_WIDTH-1:0]  pop_cnt,
    output logic [1:0]            occ
);

    localparam int DEPTH = 3;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [1:0]            wptr_q, wptr_d;
    logic [1:0]            rptr_q, rptr_d;
    logic [1:0]            occ_q, occ_d;
    logic                  infl_q, infl_d;
    logic [CNT_WIDTH-1:0]  pop_cnt_q, pop_cnt_d;

    logic room;
    logic capture;
    logic deliver;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Pop only when the word can be guaranteed a slot; m_ready is deliberately
    // kept out of this path so the FIFO enable never depends on downstream.
    assign room        = ({1'b0, occ_q} + {2'b00, infl_q}) < 3'd3;
    assign fifo_rd_enb = rstn && !fifo_empty && !flush && room;

    assign capture = infl_q && !flush;
    assign m_valid = (occ_q != 2'd0);
    assign deliver = m_valid && m_ready;

    assign occ     = occ_q;
    assign pop_cnt = pop_cnt_q;

    always_comb begin
        case (rptr_q)
            2'd0:    m_data = mem_q[0];
            2'd1:    m_data = mem_q[1];
            default: m_data = mem_q[2];
        endcase
    end

    always_comb begin
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        occ_d     = occ_q;
        infl_d    = fifo_rd_enb;
        pop_cnt_d = deliver ? pop_cnt_q + CNT_WIDTH'(1) : pop_cnt_q;
        if (flush) begin
            wptr_d = 2'd0;
            rptr_d = 2'd0;
            occ_d  = 2'd0;
            infl_d = 1'b0;
        end else begin
            if (capture) wptr_d = ptr_inc(wptr_q);
            if (deliver) rptr_d = ptr_inc(rptr_q);
            case ({capture, deliver})
                2'b10:   occ_d = occ_q + 2'd1;
                2'b01:   occ_d = occ_q - 2'd1;
                default: occ_d = occ_q;
            endcase
        end
    end

    always_ff @(posedge rd_clk or negedge rstn) begin
        if (!rstn) begin
            wptr_q    <= 2'd0;
            rptr_q    <= 2'd0;
            occ_q     <= 2'd0;
            infl_q    <= 1'b0;
            pop_cnt_q <= '0;
        end else begin
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            occ_q     <= occ_d;
            infl_q    <= infl_d;
            pop_cnt_q <= pop_cnt_d;
        end
    end

    // A word arriving in a flush cycle belongs to the discarded stream.
    for (genvar g = 0; g < DEPTH; g++) begin : g_entry
        always_ff @(posedge rd_clk or negedge rstn) begin
            if (!rstn) begin
                mem_q[g] <= '0;
            end else if (capture && (wptr_q == 2'(g))) begin
                mem_q[g] <= fifo_rd_data;
            end
        end
    end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: FIFO model plus scoreboard, a cycle table for the
// backpressure/flush corners, and directed reset, streaming and wrap checks.
module tb_fifo_rd_stream;

    logic       rd_clk = 1'b0;
    logic       rstn;
    logic       fifo_empty;
    logic [7:0] fifo_rd_data;
    logic       fifo_rd_enb;
    logic       flush;
    logic       m_valid;
    logic       m_ready;
    logic [7:0] m_data;
    logic [15:0] pop_cnt;
    logic [1:0] occ;

    logic       enb4, valid4;
    logic [7:0] data4;
    logic [3:0] pop_cnt4;
    logic [1:0] occ4;

    logic [7:0] mem [0:255];
    int         wr_idx = 0;
    int         rd_idx = 0;
    logic       force_empty;
    logic       infl_m;
    logic [7:0] sb [$];
    int         exp_cnt = 0;
    int         nchk = 0;
    int         nfail = 0;

    always #5 rd_clk = ~rd_clk;

    assign fifo_empty = force_empty || (rd_idx == wr_idx);

    fifo_rd_stream #(.DATA_WIDTH(8), .CNT_WIDTH(16)) u_dut (
        .rd_clk(rd_clk), .rstn(rstn), .fifo_empty(fifo_empty),
        .fifo_rd_data(fifo_rd_data), .fifo_rd_enb(fifo_rd_enb), .flush(flush),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .pop_cnt(pop_cnt), .occ(occ)
    );

    // Same stimulus, narrow counter: runs in lockstep with u_dut.
    fifo_rd_stream #(.DATA_WIDTH(8), .CNT_WIDTH(4)) u_dut4 (
        .rd_clk(rd_clk), .rstn(rstn), .fifo_empty(fifo_empty),
        .fifo_rd_data(fifo_rd_data), .fifo_rd_enb(enb4), .flush(flush),
        .m_valid(valid4), .m_ready(m_ready), .m_data(data4),
        .pop_cnt(pop_cnt4), .occ(occ4)
    );

    task automatic chk(input string nm, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // FIFO with one-cycle read latency; every popped word is expected downstream
    // unless a flush or reset discards it.
    always @(posedge rd_clk or negedge rstn) begin
        if (!rstn) begin
            rd_idx       <= wr_idx;
            fifo_rd_data <= 8'h00;
            infl_m       <= 1'b0;
            sb.delete();
        end else begin
            infl_m <= fifo_rd_enb;
            if (flush) sb.delete();
            if (fifo_rd_enb) begin
                fifo_rd_data <= mem[rd_idx[7:0]];
                sb.push_back(mem[rd_idx[7:0]]);
                rd_idx <= rd_idx + 1;
            end
        end
    end

    always @(negedge rd_clk) begin
        if (!rstn) begin
            exp_cnt = 0;
        end else begin
            chk("pop_cnt", int'(pop_cnt), exp_cnt % 65536);
            chk("pop_cnt4", int'(pop_cnt4), exp_cnt % 16);
            chk("occ_plus_infl_le3", int'((occ + infl_m) <= 3), 1);
            if (m_valid && m_ready) begin
                if (sb.size() == 0) begin
                    chk("sb_unexpected_word", int'(m_data), -1);
                end else begin
                    chk("sb_data", int'(m_data), int'(sb.pop_front()));
                end
                exp_cnt++;
            end
        end
    end

    task automatic push(input logic [7:0] d);
        mem[wr_idx[7:0]] = d;
        wr_idx++;
    endtask

    task automatic cyc();
        @(posedge rd_clk);
        #1;
    endtask

    task automatic drain(input string nm);
        bit ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge rd_clk);
            if (rd_idx == wr_idx && sb.size() == 0 && occ == 2'd0 && !infl_m) begin
                ok = 1;
                break;
            end
            cyc();
        end
        chk(nm, int'(ok), 1);
        cyc();
    endtask

    typedef struct {
        bit   emp;
        bit   rdy;
        bit   fl;
        int   occ;
        bit   enb;
        bit   vld;
        int   dat;
    } vec_t;

    vec_t tbl [15];

    initial begin
        bit ok;

        tbl[0]  = '{0, 0, 0, 0, 1, 0, 0};
        tbl[1]  = '{0, 0, 0, 0, 1, 0, 0};
        tbl[2]  = '{0, 0, 0, 1, 1, 1, 8'hA1};
        tbl[3]  = '{0, 0, 0, 2, 0, 1, 8'hA1};
        tbl[4]  = '{0, 0, 0, 3, 0, 1, 8'hA1};
        tbl[5]  = '{0, 1, 0, 3, 0, 1, 8'hA1};
        tbl[6]  = '{0, 0, 0, 2, 1, 1, 8'hA2};
        tbl[7]  = '{0, 0, 0, 2, 0, 1, 8'hA2};
        tbl[8]  = '{1, 1, 0, 3, 0, 1, 8'hA2};
        tbl[9]  = '{1, 1, 0, 2, 0, 1, 8'hA3};
        tbl[10] = '{0, 1, 0, 1, 1, 1, 8'hA4};
        tbl[11] = '{0, 1, 0, 0, 1, 0, 0};
        tbl[12] = '{0, 0, 0, 1, 1, 1, 8'hA5};
        tbl[13] = '{0, 0, 1, 2, 0, 1, 8'hA5};
        tbl[14] = '{0, 0, 0, 0, 1, 0, 0};

        rstn = 1'b0; force_empty = 1'b0; m_ready = 1'b0; flush = 1'b0;

        // Reset holds the pop request low even with a non-empty FIFO.
        cyc();
        push(8'h55);
        @(negedge rd_clk);
        chk("rst_enb", int'(fifo_rd_enb), 0);
        chk("rst_valid", int'(m_valid), 0);
        chk("rst_data", int'(m_data), 0);
        chk("rst_occ", int'(occ), 0);
        chk("rst_cnt", int'(pop_cnt), 0);
        cyc();
        rstn = 1'b1;

        // Mid-stream async reset with two words buffered.
        for (int i = 0; i < 8; i++) push(8'hB1 + 8'(i));
        m_ready = 1'b1;
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge rd_clk);
            if (pop_cnt >= 16'd2) begin ok = 1; break; end
            cyc();
        end
        chk("pre_rst_deliver", int'(ok), 1);
        cyc();
        m_ready = 1'b0;
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge rd_clk);
            if (occ == 2'd2) begin ok = 1; break; end
            cyc();
        end
        chk("pre_rst_occ2", int'(ok), 1);
        #2 rstn = 1'b0;
        #1;
        chk("async_rst_valid", int'(m_valid), 0);
        chk("async_rst_data", int'(m_data), 0);
        chk("async_rst_occ", int'(occ), 0);
        chk("async_rst_cnt", int'(pop_cnt), 0);
        chk("async_rst_enb", int'(fifo_rd_enb), 0);
        cyc();
        cyc();
        force_empty = 1'b1;
        rstn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge rd_clk);
            chk("post_rst_idle", int'({m_valid, occ, fifo_rd_enb}), 0);
            cyc();
        end

        // Streaming: 16 words, 2-edge latency, no bubbles.
        for (int i = 1; i <= 16; i++) push(8'(i));
        m_ready = 1'b1;
        cyc();
        force_empty = 1'b0;
        @(negedge rd_clk);
        chk("stream_first_enb", int'(fifo_rd_enb), 1);
        chk("stream_lat0_valid", int'(m_valid), 0);
        @(negedge rd_clk);
        chk("stream_lat1_valid", int'(m_valid), 0);
        for (int i = 0; i < 16; i++) begin
            @(negedge rd_clk);
            chk("stream_nobubble", int'(m_valid), 1);
            chk("stream_data", int'(m_data), i + 1);
        end
        @(negedge rd_clk);
        chk("stream_end_valid", int'(m_valid), 0);
        chk("stream_cnt16", int'(pop_cnt), 16);
        cyc();

        // Cycle table: backpressure fill to 3, empty toggling, flush with occ=2 + in-flight.
        force_empty = 1'b1;
        m_ready = 1'b0;
        for (int i = 0; i < 8; i++) push(8'hA1 + 8'(i));
        cyc();
        cyc();
        for (int r = 0; r < 15; r++) begin
            force_empty = tbl[r].emp;
            m_ready     = tbl[r].rdy;
            flush       = tbl[r].fl;
            @(negedge rd_clk);
            chk($sformatf("tbl%0d_occ", r), int'(occ), tbl[r].occ);
            chk($sformatf("tbl%0d_enb", r), int'(fifo_rd_enb), int'(tbl[r].enb));
            chk($sformatf("tbl%0d_valid", r), int'(m_valid), int'(tbl[r].vld));
            if (tbl[r].vld) chk($sformatf("tbl%0d_data", r), int'(m_data), tbl[r].dat);
            cyc();
        end
        flush = 1'b0;
        force_empty = 1'b0;
        m_ready = 1'b1;
        @(negedge rd_clk);
        chk("post_flush_valid", int'(m_valid), 0);
        cyc();
        drain("flush_drain");

        // Alternating empty with random backpressure.
        for (int i = 0; i < 40; i++) push(8'(i * 7 + 3));
        ok = 0;
        for (int i = 0; i < 600; i++) begin
            force_empty = ~force_empty;
            m_ready = 1'($urandom_range(0, 1));
            @(negedge rd_clk);
            if (rd_idx == wr_idx && sb.size() == 0 && occ == 2'd0 && !infl_m) begin
                ok = 1;
                break;
            end
            cyc();
        end
        chk("alt_empty_done", int'(ok), 1);
        cyc();
        force_empty = 1'b0;
        m_ready = 1'b1;

        // Counter wrap on the 4-bit instance.
        rstn = 1'b0;
        cyc();
        force_empty = 1'b1;
        rstn = 1'b1;
        for (int i = 0; i < 17; i++) push(8'h60 + 8'(i));
        cyc();
        force_empty = 1'b0;
        drain("wrap_drain");
        @(negedge rd_clk);
        chk("wrap_cnt16", int'(pop_cnt), 17);
        chk("wrap_cnt4", int'(pop_cnt4), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
